// File: rtl/ram_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_scan_driver_if
//  Description : Bus bundle between ram_scan_driver and its surroundings
//                (mode/switch inputs, RAM read port, display outputs).
//                master = the scan driver, slave = RAM, switches and display.
//  Signals     : scan_en    1       auto-scan (1) / manual (0) select
//                man_addr   ADDR_W  manual address from switches
//                hold       1       freeze display registers
//                rd_data    DATA_W  RAM read data
//                rd_addr    ADDR_W  RAM read address
//                disp_addr  8       displayed address, zero-extended
//                disp_data  8       displayed data, zero-extended
//                disp_valid 1       display holds a real RAM read
//  Revision    : 1.0  initial release
// ============================================================================
interface ram_scan_driver_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
);
    logic              scan_en;
    logic [ADDR_W-1:0] man_addr;
    logic              hold;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        disp_addr;
    logic [7:0]        disp_data;
    logic              disp_valid;

    modport master (
        input  scan_en, man_addr, hold, rd_data,
        output rd_addr, disp_addr, disp_data, disp_valid
    );

    modport slave (
        output scan_en, man_addr, hold, rd_data,
        input  rd_addr, disp_addr, disp_data, disp_valid
    );
endinterface
`default_nettype wire

// File: rtl/ram_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : ram_scan_driver
//  Description : Generates the read address of a small synchronous RAM, either
//                stepping through all words on a slow tick (scan mode) or
//                following a manual address (manual mode), and presents a
//                coherent (address, data) byte pair to two hex-digit decoders.
//  Ports       : clk      system clock, rising edge
//                reset_n  asynchronous active-low reset
//                bus      ram_scan_driver_if.master (mode/switch inputs, RAM
//                         read port, display outputs)
//  Parameters  : ADDR_W 1..8, DATA_W 1..8, TICK_DIV >= 2, READ_LAT >= 1
//  Revision    : 1.0  initial release
// ============================================================================
module ram_scan_driver #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int READ_LAT = 1
) (
    input  wire                 clk,
    input  wire                 reset_n,
    ram_scan_driver_if.master   bus
);

    localparam int c_PRESC_W = $clog2(TICK_DIV);
    localparam logic [c_PRESC_W-1:0] c_TICK_LAST = c_PRESC_W'(TICK_DIV - 1);

    typedef enum logic [0:0] {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_PRESC_W-1:0] r_presc;
    logic [c_PRESC_W-1:0] w_presc_nxt;
    logic [ADDR_W-1:0]    r_rd_addr;
    logic [ADDR_W-1:0]    w_addr_nxt;
    logic                 w_tick;

    // Address/valid delay line, aligned so that its last stage names the
    // word currently presented on rd_data.
    logic [ADDR_W-1:0]    r_pipe_addr [READ_LAT];
    logic [READ_LAT-1:0]  r_pipe_vld;

    logic [7:0]           r_disp_addr;
    logic [7:0]           r_disp_data;
    logic                 r_disp_valid;

    assign w_tick = (r_state == ST_SCAN) && (r_presc == c_TICK_LAST);

    // ------------------------------------------------------------------
    // Mode FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_MANUAL;
            r_presc   <= '0;
            r_rd_addr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_rd_addr <= w_addr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Mode FSM: next state, prescaler and address
    // The prescaler defaults to 0, so it sits at 0 in manual mode and is
    // cleared both on a tick and on any mode change. A mode change takes
    // priority over a coincident tick, so leaving scan never increments.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = '0;
        w_addr_nxt  = r_rd_addr;
        case (r_state)
            ST_MANUAL: begin
                w_addr_nxt = bus.man_addr;
                if (bus.scan_en) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!bus.scan_en) begin
                    w_state_nxt = ST_MANUAL;
                end else if (w_tick) begin
                    w_addr_nxt = r_rd_addr + 1'b1;
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_MANUAL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read pipeline: shifts the issued address alongside the RAM latency.
    // The valid bit enters as 1 on every post-reset cycle, so it reaches
    // the display exactly when the first real read does.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_pipe_addr[i] <= '0;
            end
            r_pipe_vld <= '0;
        end else begin
            r_pipe_addr[0] <= r_rd_addr;
            r_pipe_vld[0]  <= 1'b1;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pipe_addr[i] <= r_pipe_addr[i-1];
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Display registers: address and data are captured together, so the
    // pair stays coherent even across hold.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_disp_addr  <= '0;
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
        end else if (!bus.hold) begin
            r_disp_addr  <= 8'(r_pipe_addr[READ_LAT-1]);
            r_disp_data  <= 8'(bus.rd_data);
            r_disp_valid <= r_pipe_vld[READ_LAT-1];
        end
    end

    assign bus.rd_addr    = r_rd_addr;
    assign bus.disp_addr  = r_disp_addr;
    assign bus.disp_data  = r_disp_data;
    assign bus.disp_valid = r_disp_valid;

endmodule
`default_nettype wire

// File: tb/tb_ram_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_scan_driver
//  Description : Self-checking bench for ram_scan_driver (TICK_DIV=4,
//                READ_LAT=1, ADDR_W=5, DATA_W=4). RAM word k holds k%16.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_scan_driver;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 4;
    localparam int TICK_DIV = 4;
    localparam int READ_LAT = 1;
    localparam int NWORDS   = 1 << ADDR_W;

    logic clk;
    logic reset_n;

    ram_scan_driver_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_scan_driver #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TICK_DIV(TICK_DIV),
        .READ_LAT(READ_LAT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM, one cycle latency, word k = k % 16
    initial bus.rd_data = '0;
    always @(posedge clk) begin
        bus.rd_data <= DATA_W'(int'(bus.rd_addr) % 16);
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Scan address is derived from the number of scan
    // cycles elapsed since the scan started: base + floor(n / TICK_DIV).
    // Display shows the address issued two edges earlier (one RAM cycle
    // plus the display register) unless hold is set.
    // ------------------------------------------------------------------
    bit m_scan;
    int m_base, m_n, m_addr, m_new;
    int hist0, hist1;
    bit vh;
    int m_dispa;
    bit m_valid;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_scan = 0; m_base = 0; m_n = 0; m_addr = 0;
            hist0 = 0; hist1 = 0; vh = 0; m_dispa = 0; m_valid = 0;
        end else begin
            if (!m_scan) begin
                m_new = int'(bus.man_addr);
                if (bus.scan_en) begin
                    m_scan = 1; m_base = m_new; m_n = 0;
                end
            end else if (!bus.scan_en) begin
                m_scan = 0;
                m_new  = m_addr;
            end else begin
                m_n++;
                m_new = (m_base + m_n / TICK_DIV) % NWORDS;
            end
            if (!bus.hold) begin
                m_dispa = hist1;
                m_valid = vh;
            end
            hist1  = hist0;
            hist0  = m_new;
            vh     = 1;
            m_addr = m_new;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_rd_addr",    32'(bus.rd_addr),    0);
            chk("rst_disp_addr",  32'(bus.disp_addr),  0);
            chk("rst_disp_data",  32'(bus.disp_data),  0);
            chk("rst_disp_valid", 32'(bus.disp_valid), 0);
        end else begin
            chk("rd_addr",    32'(bus.rd_addr),    32'(m_addr));
            chk("disp_valid", 32'(bus.disp_valid), 32'(m_valid));
            chk("disp_addr",  32'(bus.disp_addr),  32'(m_dispa));
            if (m_valid) begin
                chk("disp_data", 32'(bus.disp_data), 32'(m_dispa % 16));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.scan_en  = 1'b0;
        bus.man_addr = '0;
        bus.hold     = 1'b0;
        step(3);
        chk("lit_reset_valid", 32'(bus.disp_valid), 0);
        chk("lit_reset_rd",    32'(bus.rd_addr),    0);

        // Reset release: valid after the second edge with reset_n high
        reset_n = 1'b1;
        step(1);
        chk("lit_valid_edge1", 32'(bus.disp_valid), 0);
        step(1);
        chk("lit_valid_edge2", 32'(bus.disp_valid), 1);

        // Manual mode
        bus.man_addr = 5'h1A;
        step(1);
        chk("lit_man_rd", 32'(bus.rd_addr), 32'h1A);
        step(2);
        chk("lit_man_disp_addr", 32'(bus.disp_addr), 32'h1A);
        chk("lit_man_disp_data", 32'(bus.disp_data), 32'h0A);

        // Scan with wrap 1E,1F,00,01
        bus.man_addr = 5'h1E;
        step(1);
        chk("lit_scan_start", 32'(bus.rd_addr), 32'h1E);
        bus.scan_en = 1'b1;
        step(1);                                           // E0
        step(3);                                           // E3
        chk("lit_scan_e3", 32'(bus.rd_addr), 32'h1E);
        step(1);                                           // E4
        chk("lit_scan_e4", 32'(bus.rd_addr), 32'h1F);
        step(1);                                           // E5
        chk("lit_scan_disp_e5", 32'(bus.disp_addr), 32'h1E);
        step(1);                                           // E6
        chk("lit_scan_disp_e6", 32'(bus.disp_addr), 32'h1F);
        chk("lit_scan_data_e6", 32'(bus.disp_data), 32'h0F);
        step(2);                                           // E8
        chk("lit_scan_e8", 32'(bus.rd_addr), 32'h00);
        step(4);                                           // E12
        chk("lit_scan_e12", 32'(bus.rd_addr), 32'h01);

        // Drop scan_en on the tick cycle: no increment
        step(3);                                           // E15, prescaler at last
        bus.scan_en  = 1'b0;
        bus.man_addr = 5'h07;
        step(1);
        chk("lit_simul_noinc", 32'(bus.rd_addr), 32'h01);
        step(1);
        chk("lit_simul_manual", 32'(bus.rd_addr), 32'h07);

        // Hold in scan for 12 cycles
        bus.man_addr = 5'h03;
        step(1);
        bus.scan_en = 1'b1;
        step(1);                                           // E0
        step(2);                                           // E2
        chk("lit_hold_pre", 32'(bus.disp_addr), 32'h03);
        bus.hold = 1'b1;
        step(12);                                          // E14
        chk("lit_hold_frozen_a", 32'(bus.disp_addr), 32'h03);
        chk("lit_hold_frozen_d", 32'(bus.disp_data), 32'h03);
        chk("lit_hold_rd_adv",   32'(bus.rd_addr),   32'h06);
        bus.hold = 1'b0;
        step(1);                                           // E15
        chk("lit_hold_rel_a", 32'(bus.disp_addr), 32'h06);
        chk("lit_hold_rel_d", 32'(bus.disp_data), 32'h06);

        // Asynchronous reset mid-operation
        @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("lit_async_rd",    32'(bus.rd_addr),    0);
        chk("lit_async_da",    32'(bus.disp_addr),  0);
        chk("lit_async_dd",    32'(bus.disp_data),  0);
        chk("lit_async_valid", 32'(bus.disp_valid), 0);
        step(2);
        reset_n = 1'b1;

        // Randomised coherence run
        for (int i = 0; i < 3000; i++) begin
            step(1);
            if ($urandom_range(0, 15) == 0) bus.scan_en = ~bus.scan_en;
            bus.man_addr = ADDR_W'($urandom_range(0, NWORDS - 1));
            bus.hold     = ($urandom_range(0, 7) == 0);
            if (i == 1500) begin
                #2 reset_n = 1'b0;
                #1 chk("lit_rand_rst_valid", 32'(bus.disp_valid), 0);
            end
            if (i == 1502) reset_n = 1'b1;
            if (bus.disp_valid) begin
                chk("disp_addr_upper", 32'(bus.disp_addr[7:ADDR_W]), 0);
            end
        end

        step(1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
